// File: rtl/pulse_pkg.sv
// Shared pulse-path definitions: DAC sample width and the DAC sample buffer state type.
package pulse_pkg;

  localparam int DAC_SAMPLE_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    PLAY
  } dac_buf_state_t;

endpackage

// File: rtl/dac_buf_fifo.sv
// Single-clock synchronous FIFO with separately tracked occupancy and a synchronous flush.
module dac_buf_fifo #(
  parameter int  DEPTH = 64,
  parameter int  WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; level gates every read, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dac_sample_buffer.sv
// Elastic buffer between the pulse scheduler stream and the DAC: primes, then plays one sample per strobe.
// Optional saturating starvation counter is built when DAC_STARVE_CNT_EN is defined.
module dac_sample_buffer
  import pulse_pkg::*;
#(
  parameter int                      DEPTH         = 64,
  parameter int                      PRIME_LEVEL   = 8,
  parameter int                      PRIME_TIMEOUT = 16,
  parameter logic [DAC_SAMPLE_W-1:0] IDLE_CODE     = '0,
  localparam int                     LW            = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DAC_SAMPLE_W-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    dac_en,
  input  logic                    flush,
  output logic [DAC_SAMPLE_W-1:0] dac_data,
  output logic                    dac_valid,
  output logic [LW-1:0]           level,
  output logic                    starve,
  input  logic                    starve_clr,
  output logic [15:0]             starve_count
);

  localparam int CW = $clog2(PRIME_TIMEOUT + 1);

  dac_buf_state_t          state, state_nxt;
  logic [CW-1:0]           idle_cnt, idle_cnt_nxt;
  logic [DAC_SAMPLE_W-1:0] head;
  logic                    full, empty;
  logic                    push, pop, starve_evt, prime_done;

  dac_buf_fifo #(.DEPTH(DEPTH), .WIDTH(DAC_SAMPLE_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (s_axis_tdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign s_axis_tready = !full && !flush;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = (state == PLAY) && dac_en && !empty;
  // A same-cycle push leaves occupancy non-zero, so that strobe is not starvation.
  assign starve_evt    = (state == PLAY) && dac_en && empty && !push && !flush;
  assign prime_done    = (level >= LW'(PRIME_LEVEL)) ||
                         ((idle_cnt == CW'(PRIME_TIMEOUT)) && !empty);

  // NOTE: defaults are assigned first so every path drives every output and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = '0;
    case (state)
      IDLE:    if (push) state_nxt = PRIME;
      PRIME: begin
        if (prime_done)  state_nxt    = PLAY;
        else if (!push)  idle_cnt_nxt = idle_cnt + 1'b1;
      end
      PLAY:    if (starve_evt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt    = IDLE;
      idle_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idle_cnt  <= '0;
      dac_data  <= IDLE_CODE;
      dac_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
      if (flush) begin
        dac_data  <= IDLE_CODE;
        dac_valid <= 1'b0;
      end else if (pop) begin
        dac_data  <= head;
        dac_valid <= 1'b1;
      end else begin
        dac_valid <= 1'b0;
        if (state != PLAY || starve_evt) dac_data <= IDLE_CODE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          starve <= 1'b0;
    else if (starve_evt) starve <= 1'b1;
    else if (starve_clr) starve <= 1'b0;
  end

`ifdef DAC_STARVE_CNT_EN
  logic [15:0] starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (starve_evt) begin
      if (starve_cnt != 16'hFFFF) starve_cnt <= starve_cnt + 1'b1;
    end else if (starve_clr) begin
      starve_cnt <= '0;
    end
  end

  assign starve_count = starve_cnt;
`else
  assign starve_count = 16'h0;
`endif

endmodule

// File: tb/tb_dac_sample_buffer.sv
// Self-checking bench for dac_sample_buffer: vector table, directed corner sequences, randomized traffic vs a queue model.
module tb_dac_sample_buffer;
  import pulse_pkg::*;

  localparam int          DEPTH         = 64;
  localparam int          PRIME_LEVEL   = 8;
  localparam int          PRIME_TIMEOUT = 16;
  localparam logic [31:0] IDLE_CODE     = 32'h0;
  localparam int          LW            = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          dac_en = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   dac_data;
  logic          dac_valid;
  logic [LW-1:0] level;
  logic          starve;
  logic          starve_clr = 1'b0;
  logic [15:0]   starve_count;

  always #5 clk = ~clk;

  dac_sample_buffer #(
    .DEPTH(DEPTH), .PRIME_LEVEL(PRIME_LEVEL), .PRIME_TIMEOUT(PRIME_TIMEOUT), .IDLE_CODE(IDLE_CODE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .dac_en(dac_en), .flush(flush), .dac_data(dac_data),
    .dac_valid(dac_valid), .level(level), .starve(starve), .starve_clr(starve_clr),
    .starve_count(starve_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the buffer as a queue plus a playback mode.
  typedef enum {M_IDLE, M_PRIME, M_PLAY} mode_t;
  logic [31:0] mq[$];
  mode_t       m_mode;
  int          m_quiet;
  logic [31:0] m_data;
  bit          m_valid;
  bit          m_starve;
  int          m_cnt;

  function automatic void model_reset();
    mq.delete();
    m_mode   = M_IDLE;
    m_quiet  = 0;
    m_data   = IDLE_CODE;
    m_valid  = 0;
    m_starve = 0;
    m_cnt    = 0;
  endfunction

  task automatic compare_outputs(input string tag);
    check({tag, ".level"},        level,        mq.size());
    check({tag, ".dac_data"},     dac_data,     m_data);
    check({tag, ".dac_valid"},    dac_valid,    m_valid);
    check({tag, ".starve"},       starve,       m_starve);
    check({tag, ".starve_count"}, starve_count, m_cnt);
  endtask

  // Drives one clock of inputs from posedge+1, predicts the result and compares after the edge.
  task automatic cycle(input bit tv, input logic [31:0] td, input bit en, input bit fl, input bit sc);
    bit rdy, push, pop, ev, go;
    s_axis_tvalid = tv;
    s_axis_tdata  = td;
    dac_en        = en;
    flush         = fl;
    starve_clr    = sc;
    #1;
    rdy  = (mq.size() < DEPTH) && !fl;
    check("tready", s_axis_tready, rdy);
    push = tv && rdy;
    pop  = (m_mode == M_PLAY) && en && (mq.size() > 0);
    ev   = (m_mode == M_PLAY) && en && !fl && (mq.size() == 0) && !push;
    go   = (mq.size() >= PRIME_LEVEL) || ((m_quiet >= PRIME_TIMEOUT) && (mq.size() > 0));
    if (ev) begin
      m_starve = 1;
`ifdef DAC_STARVE_CNT_EN
      if (m_cnt < 65535) m_cnt++;
`endif
    end else if (sc) begin
      m_starve = 0;
      m_cnt    = 0;
    end
    if (fl) begin
      mq.delete();
      m_mode  = M_IDLE;
      m_quiet = 0;
      m_data  = IDLE_CODE;
      m_valid = 0;
    end else begin
      m_valid = pop;
      if (pop)                          m_data = mq.pop_front();
      else if (ev || m_mode != M_PLAY)  m_data = IDLE_CODE;
      if (push) mq.push_back(td);
      case (m_mode)
        M_IDLE:  if (push) begin m_mode = M_PRIME; m_quiet = 0; end
        M_PRIME: if (go) begin m_mode = M_PLAY; m_quiet = 0; end
                 else m_quiet = push ? 0 : m_quiet + 1;
        M_PLAY:  if (ev) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
    compare_outputs("cyc");
  endtask

  task automatic flush_clear();
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) cycle(1'b1, base * (i + 1), 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit          tv;
    logic [31:0] td;
    bit          en;
    bit          fl;
    bit          rdy;
    int          lvl;
    bit          vld;
    logic [31:0] data;
  } vec_t;

  function automatic vec_t mk(bit tv, logic [31:0] td, bit en, bit fl, bit rdy, int lvl, bit vld,
                              logic [31:0] data);
    vec_t v;
    v.tv = tv; v.td = td; v.en = en; v.fl = fl; v.rdy = rdy; v.lvl = lvl; v.vld = vld; v.data = data;
    return v;
  endfunction

  vec_t        vecs[14];
  logic [31:0] got[$];
  int          probs[4];
  int          p_tv, p_en;
  logic [31:0] exp_cnt;

  initial begin
    for (int i = 0; i < 8; i++) vecs[i] = mk(1, 32'h0001_0001 * (i + 1), 0, 0, 1, i + 1, 0, 32'h0);
    vecs[8]  = mk(0, 32'h0,         1, 0, 1, 8, 0, 32'h0);
    vecs[9]  = mk(0, 32'h0,         1, 0, 1, 7, 1, 32'h0001_0001);
    vecs[10] = mk(0, 32'h0,         0, 0, 1, 7, 0, 32'h0001_0001);
    vecs[11] = mk(1, 32'h0009_0009, 1, 0, 1, 7, 1, 32'h0002_0002);
    vecs[12] = mk(1, 32'h0000_00FF, 0, 1, 0, 0, 0, 32'h0);
    vecs[13] = mk(0, 32'h0,         1, 0, 1, 0, 0, 32'h0);
`ifdef DAC_STARVE_CNT_EN
    exp_cnt = 32'd1;
`else
    exp_cnt = 32'd0;
`endif

    model_reset();
    #1;
    compare_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table from a freshly reset buffer.
    for (int i = 0; i < 14; i++) begin
      s_axis_tvalid = vecs[i].tv;
      s_axis_tdata  = vecs[i].td;
      dac_en        = vecs[i].en;
      flush         = vecs[i].fl;
      starve_clr    = 1'b0;
      #1;
      check($sformatf("vec%0d.tready", i), s_axis_tready, vecs[i].rdy);
      cycle(vecs[i].tv, vecs[i].td, vecs[i].en, vecs[i].fl, 1'b0);
      check($sformatf("vec%0d.level", i), level, vecs[i].lvl);
      check($sformatf("vec%0d.valid", i), dac_valid, vecs[i].vld);
      check($sformatf("vec%0d.data", i), dac_data, vecs[i].data);
      check($sformatf("vec%0d.starve", i), starve, 1'b0);
    end

    // Eight samples, strobe every 4 clocks: eight in order, then starvation on the ninth.
    flush_clear();
    push_n(8, 32'h0001_0001);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    got.delete();
    for (int s = 0; s < 9; s++) begin
      if (s == 8) check("t2.starve_before_9th", starve, 1'b0);
      for (int k = 0; k < 4; k++) begin
        cycle(1'b0, '0, k == 0, 1'b0, 1'b0);
        if (dac_valid) got.push_back(dac_data);
      end
    end
    check("t2.pop_count", got.size(), 8);
    for (int i = 0; i < got.size(); i++) check($sformatf("t2.sample%0d", i), got[i], 32'h0001_0001 * (i + 1));
    check("t2.starve_after_9th", starve, 1'b1);
    check("t2.starve_count", starve_count, exp_cnt);

    // Short pulse: three samples, prime timeout forces playback.
    flush_clear();
    push_n(3, 32'h00A0_00A0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    got.delete();
    for (int s = 0; s < 4; s++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      if (dac_valid) got.push_back(dac_data);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    check("t3.pop_count", got.size(), 3);
    check("t3.last_sample", got[got.size() - 1], 32'h01E0_01E0);
    check("t3.starve", starve, 1'b1);
    check("t3.starve_count", starve_count, exp_cnt);

    // Fill to DEPTH, hold tvalid while full, then one pop reopens tready.
    flush_clear();
    push_n(DEPTH, 32'h0000_0100);
    check("t4.level_full", level, DEPTH);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    check("t4.level_held", level, DEPTH);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    check("t4.first_pop", dac_data, 32'h0000_0100);
    s_axis_tvalid = 1'b0;
    #1;
    check("t4.tready_after_pop", s_axis_tready, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Level 1 in playback, push and strobe together.
    flush_clear();
    push_n(8, 32'h0001_0001);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t5.level_before", level, 1);
    cycle(1'b1, 32'h0055_0055, 1'b1, 1'b0, 1'b0);
    check("t5.data", dac_data, 32'h0008_0008);
    check("t5.valid", dac_valid, 1'b1);
    check("t5.level", level, 1);
    check("t5.starve", starve, 1'b0);

    // Flush with a pending write, then a clear racing a starvation event.
    flush_clear();
    push_n(20, 32'h0000_0011);
    cycle(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    check("t6.flush_level", level, 0);
    check("t6.flush_data", dac_data, IDLE_CODE);
    push_n(8, 32'h0000_0022);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("t6.set_wins", starve, 1'b1);
    check("t6.count_set_wins", starve_count, exp_cnt);

    // Asynchronous reset in the middle of playback at level 5.
    push_n(8, 32'h0000_0033);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t1.level_before", level, 5);
    s_axis_tvalid = 1'b0;
    dac_en        = 1'b0;
    rst_n         = 1'b0;
    #2;
    model_reset();
    check("t1.level", level, 0);
    check("t1.dac_data", dac_data, 32'h0);
    check("t1.dac_valid", dac_valid, 1'b0);
    check("t1.starve", starve, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t1.idle_no_starve", starve, 1'b0);

    // Randomized bursts against the model.
    probs[0] = 0; probs[1] = 15; probs[2] = 50; probs[3] = 90;
    for (int blk = 0; blk < 24; blk++) begin
      p_tv = probs[$urandom_range(0, 3)];
      p_en = int'($urandom_range(5, 40));
      for (int c = 0; c < 100; c++)
        cycle(int'($urandom_range(0, 99)) < p_tv, $urandom, int'($urandom_range(0, 99)) < p_en,
              $urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
